// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH bits.
//   A single full-subtractor cell and a borrow flop retire one bit per clock.
//   Operands are captured on an accepted start and the result is held until
//   the next completed operation.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   start       request, sampled only while busy = 0
//   a, b        minuend / subtrahend, captured when start is accepted
//   busy        high while an operation is running or completing
//   done        one-cycle pulse when diff/borrow_out/ovf update
//   diff        (a - b) mod 2^WIDTH
//   borrow_out  1 iff a < b (unsigned)
//   ovf         signed (two's-complement) overflow
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; result outputs hold the last result
// RUN    | one bit per clock through the full-subtractor cell
// DONE   | result just updated, done pulse asserted for this cycle

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell on the current LSBs.
  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_shifted;

  assign d_bit       = a_sh_q[0] ^ b_sh_q[0] ^ bw_q;
  assign bw_next     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bw_q);
  assign res_shifted = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          bw_d    = 1'b0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shifted;
        bw_d   = bw_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // d_bit is the result MSB on the final bit.
          diff_d   = res_shifted;
          borrow_d = bw_next;
          ovf_d    = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

endmodule
